// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: ROB tag width and the packed CDB beat that parents
// pack the arbiter outputs into.
package cdb_arbiter_pkg;
  localparam int ROB_WIDTH = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set req at or after prio, mod N.
module rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] prio,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [2*N-1:0] req2, mask, hit;
  int pos;

  // Doubling req lets a single low-to-high scan cover the wrap past N-1.
  always_comb begin
    req2 = {req, req};
    mask = {(2*N){1'b1}} << prio;
    hit  = req2 & mask;
    pos  = 0;
    for (int j = 2*N-1; j >= 0; j--)
      if (hit[j]) pos = j;
    idx = (pos >= N) ? PW'(pos - N) : PW'(pos);
    any = |req;
    gnt = '0;
    gnt[idx] = any;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-hot rotating grant among result ports, flush
// gating and a registered single-beat CDB broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0][ROB_WIDTH-1:0]     req_tag,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_data,
  output logic                                cdb_valid,
  output logic [ROB_WIDTH-1:0]                cdb_tag,
  output logic [DATA_WIDTH-1:0]               cdb_data
);
  localparam int PW     = $clog2(N_REQ);
  localparam int STAGES = 1;

  logic [PW-1:0]    prio, idx;
  logic [N_REQ-1:0] gnt;
  logic             any;
  logic [STAGES:0]  vld_pipe;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req_valid),
    .prio (prio),
    .gnt  (gnt),
    .idx  (idx),
    .any  (any)
  );

  // Reset is folded in so no grant is shown while the CDB is held cleared.
  assign vld_pipe[0] = any & ~flush & rst_n;
  assign req_ready   = vld_pipe[0] ? gnt : '0;
  assign cdb_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      cdb_tag            <= '0;
      cdb_data           <= '0;
      prio               <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) begin
        cdb_tag  <= req_tag[idx];
        cdb_data <= req_data[idx];
        prio     <= (idx == PW'(N_REQ-1)) ? '0 : PW'(idx + 1'b1);
      end
    end
  end
endmodule
